// File: rtl/find_max_writer_pkg.sv
// Shared definitions for the find-max frame writer and its reader counterpart.
// Holds the FSM state encoding, default widths and frame depth.
package find_max_writer_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_ADDR_W = 7;
    localparam int FRAME_DEPTH    = 2 ** DEFAULT_ADDR_W;
    localparam int DECIM_W        = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_READY = 2'd2
    } wr_state_e;

endpackage

// File: rtl/find_max_writer_sample_decimator.sv
// Decimation counter: accepts every (decim+1)-th valid sample while active.
// The decimation ratio is captured on load so mid-frame changes wait for the next frame.
module sample_decimator
    import find_max_writer_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               active_i,
    input  logic               sample_valid_i,
    input  logic [DECIM_W-1:0] decim_i,
    output logic               accept_o
);

    logic [DECIM_W-1:0] cnt_q;
    logic [DECIM_W-1:0] cnt_d;
    logic [DECIM_W-1:0] decim_q;
    logic [DECIM_W-1:0] decim_d;

    assign accept_o = active_i && sample_valid_i && (cnt_q == decim_q);

    // Next-state for the counter and the latched ratio
    always_comb begin
        cnt_d   = cnt_q;
        decim_d = decim_q;
        if (load_i) begin
            cnt_d   = {DECIM_W{1'b0}};
            decim_d = decim_i;
        end else if (active_i && sample_valid_i) begin
            if (cnt_q == decim_q) begin
                cnt_d = {DECIM_W{1'b0}};
            end else begin
                cnt_d = cnt_q + {{(DECIM_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter and ratio registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= {DECIM_W{1'b0}};
            decim_q <= {DECIM_W{1'b0}};
        end else begin
            cnt_q   <= cnt_d;
            decim_q <= decim_d;
        end
    end

endmodule

// File: rtl/find_max_writer.sv
// Captures one decimated frame of samples into RAM port A, then hands it to the
// find-max reader via readyb and waits for the reader's finishb rising edge.
module find_max_writer
    import find_max_writer_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [3:0]         decim,
    input  logic               sample_valid,
    input  logic [DATA_W-1:0]  sample_data,
    input  logic               finishb,
    output logic               wea,
    output logic [ADDR_W-1:0]  addra,
    output logic [DATA_W-1:0]  dina,
    output logic               readyb,
    output logic [15:0]        frame_cnt,
    output logic               overflow
);

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [15:0]       fcnt_q, fcnt_d;
    logic              ovf_q, ovf_d;
    logic              readyb_q, readyb_d;
    logic              wea_q;
    logic [ADDR_W-1:0] addra_q;
    logic [DATA_W-1:0] dina_q;
    logic              finishb_q;
    logic              fin_edge_s;
    logic              load_s;
    logic              active_s;
    logic              accept_s;

    assign fin_edge_s = !finishb_q && finishb;
    assign active_s   = (state_q == ST_FILL) && enable;

    sample_decimator u_decim (
        .clk_in         (clk_in),
        .rst_n          (rst_n),
        .load_i         (load_s),
        .active_i       (active_s),
        .sample_valid_i (sample_valid),
        .decim_i        (decim),
        .accept_o       (accept_s)
    );

    // FSM next state, write pointer, frame counter and overflow flag
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        fcnt_d   = fcnt_q;
        ovf_d    = ovf_q;
        load_s   = 1'b0;
        readyb_d = (state_q == ST_READY) && !fin_edge_s;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_FILL;
                    load_s  = 1'b1;
                    ptr_d   = {ADDR_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    ptr_d   = {ADDR_W{1'b0}};
                end else if (accept_s) begin
                    ptr_d = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (ptr_q == {ADDR_W{1'b1}}) begin
                        state_d = ST_READY;
                        fcnt_d  = fcnt_q + 16'd1;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_READY: begin
                // A sample arriving on the release cycle is still dropped
                if (sample_valid) begin
                    ovf_d = 1'b1;
                end else begin
                    ovf_d = ovf_q;
                end
                if (fin_edge_s) begin
                    ptr_d = {ADDR_W{1'b0}};
                    if (enable) begin
                        state_d = ST_FILL;
                        load_s  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // State, control and RAM port registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= {ADDR_W{1'b0}};
            fcnt_q    <= 16'd0;
            ovf_q     <= 1'b0;
            readyb_q  <= 1'b0;
            finishb_q <= 1'b0;
            wea_q     <= 1'b0;
            addra_q   <= {ADDR_W{1'b0}};
            dina_q    <= {DATA_W{1'b0}};
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            fcnt_q    <= fcnt_d;
            ovf_q     <= ovf_d;
            readyb_q  <= readyb_d;
            finishb_q <= finishb;
            wea_q     <= accept_s;
            if (accept_s) begin
                addra_q <= ptr_q;
                dina_q  <= sample_data;
            end else begin
                addra_q <= addra_q;
                dina_q  <= dina_q;
            end
        end
    end

    assign wea       = wea_q;
    assign addra     = addra_q;
    assign dina      = dina_q;
    assign readyb    = readyb_q;
    assign frame_cnt = fcnt_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/find_max_writer.md
FIND_MAX_WRITER -- requirements
Module: find_max_writer

Interface
REQ-001 Parameter DATA_W, default 8, sample and RAM data width.
REQ-002 Parameter ADDR_W, default 7, RAM address width; frame depth is 2**ADDR_W (128).
REQ-003 clk_in  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 enable  input  1  high permits frame capture.
REQ-006 decim  input  4  decimation; every (decim+1)-th valid sample is accepted.
REQ-007 sample_valid  input  1  sample_data qualifier.
REQ-008 sample_data  input  DATA_W  incoming sample (ADC).
REQ-009 finishb  input  1  from the find-max reader; a rising edge means the frame has been consumed.
REQ-010 wea  output  1  RAM port A write enable.
REQ-011 addra  output  ADDR_W  RAM port A address.
REQ-012 dina  output  DATA_W  RAM port A write data.
REQ-013 readyb  output  1  level high while a complete frame is held in RAM.
REQ-014 frame_cnt  output  16  number of completed frames, wrapping.
REQ-015 overflow  output  1  sticky; a valid sample arrived while the block could not accept it.

Function
REQ-016 FSM states are IDLE, FILL and READY.
REQ-017 IDLE goes to FILL when enable=1; on entry to FILL, write pointer=0 and decimation counter=0.
REQ-018 In FILL, a sample is accepted when sample_valid=1 and decimation counter==decim; the counter then clears, otherwise it increments on each sample_valid.
REQ-019 An accepted sample produces wea=1, addra=pointer and dina=sample_data on the next cycle (all registered, 1-cycle latency); the pointer then increments.
REQ-020 The write at address 2**ADDR_W-1 ends the frame: next state READY, readyb=1 on the cycle after that wea, and frame_cnt increments by 1.
REQ-021 READY holds readyb=1 and wea=0 until a finishb rising edge is detected (finishb registered, edge = !finishb_r & finishb).
REQ-022 On the finishb edge, readyb goes to 0 on the next cycle; the FSM goes to FILL if enable=1, else to IDLE.
REQ-023 readyb is low for at least 2**ADDR_W cycles between frames, so the reader always sees a clean rising edge.
REQ-024 sample_valid=1 in READY sets overflow; the sample is dropped.
REQ-025 If the finishb edge and sample_valid occur in the same cycle, the sample is dropped and counted as overflow.
REQ-026 If enable drops mid-FILL, the frame is aborted: go to IDLE, pointer=0, no readyb, no frame_cnt change.
REQ-027 If enable drops in READY, the block stays in READY until the finishb edge, then goes to IDLE.
REQ-028 A finishb edge outside READY is ignored.
REQ-029 decim changes take effect at the next FILL entry; the value is sampled on FILL entry.
REQ-030 overflow clears only on reset.

Reset
REQ-031 While rst_n=0: state=IDLE, wea=0, addra=0, dina=0, readyb=0, frame_cnt=0, overflow=0, pointer=0, decimation counter=0, finishb_r=0.
REQ-032 A reset during any state, including mid-FILL or READY, aborts immediately; RAM contents are don't-care.

Structure
REQ-033 A shared package holds the FSM state enumeration, the DATA_W/ADDR_W defaults and the FRAME_DEPTH constant, for reuse by the reader side.
REQ-034 One sub-module, sample_decimator, implements the decimation counter and outputs accept.

Verification
REQ-035 decim=0, enable=1, 128 consecutive samples 0..127 -> wea at addra 0..127 with dina=addra, readyb=1 one cycle after the last write, frame_cnt=1.
REQ-036 decim=3, 512 valid samples -> exactly 128 writes with dina equal to every 4th sample (3,7,11,...), then readyb=1.
REQ-037 In READY, 5 valid samples then a finishb pulse -> no writes, overflow=1, readyb=0 next cycle, second frame fills from addra=0.
REQ-038 enable=0 after 60 writes -> state IDLE, no readyb, frame_cnt unchanged; re-enable -> writes restart at addra=0.
REQ-039 rst_n asserted asynchronously mid-READY (between clock edges) -> readyb, frame_cnt and overflow are 0 immediately, without waiting for a clock edge.
REQ-040 finishb toggled in IDLE/FILL -> no effect; in READY, finishb held high for 10 cycles -> exactly one release.
